multdiv_unit: RTL and testbench

- Iterative signed 32-bit multiply/divide unit that sits in the execute (DX) stage beside the ALU.
- Produces results that feed the XM latch.
- Started by a one-cycle control pulse when the DX instruction is an R-type mul/div (ALU op 00110 / 00111).
- Reports completion with a one-cycle ready strobe; the pipeline stalls FD/DX until that strobe.

---
 rtl/multdiv_unit_if.sv | 24 ++
 rtl/multdiv_unit.sv | 130 +++++++++++++
 tb/tb_multdiv_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/multdiv_unit_if.sv
// Operand/control/result bundle between the DX stage and the multiply/divide unit.
// The master drives operands and start pulses, the slave returns results and status.
interface multdiv_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit for the DX stage.
// One iteration per cycle over operand magnitudes; sign is applied on the final iteration.
module multdiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic           clock,
   input logic           reset,
   multdiv_unit_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic               neg;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   divisor;
   logic               div_zero;
   logic               div_ovf;

   logic [WIDTH-1:0]   result;
   logic               exception;

   logic               start;
   logic               last;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] mul_sum, mul_final;
   logic               mul_ovf;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   rem_sub, rem_next, quo_next, div_final;
   logic               take;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   assign start = bus.ctrl_MULT | bus.ctrl_DIV;
   assign last  = (cnt == CW'(WIDTH - 1));
   assign mag_a = magnitude(bus.data_operandA);
   assign mag_b = magnitude(bus.data_operandB);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     state_nxt = IDLE;
         MUL, DIV: if (last) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      // A start pulse in any state abandons the current operation; MULT has priority.
      if (bus.ctrl_MULT)     state_nxt = MUL;
      else if (bus.ctrl_DIV) state_nxt = DIV;
   end

   always_comb begin
      mul_sum   = acc + (mplier[0] ? mcand : '0);
      mul_final = neg ? -mul_sum : mul_sum;
      mul_ovf   = !((&mul_final[2*WIDTH-1:WIDTH-1]) || !(|mul_final[2*WIDTH-1:WIDTH-1]));

      // The partial remainder is always below the divisor, so WIDTH bits hold it.
      rem_sh    = {rem, quo[WIDTH-1]};
      take      = (rem_sh >= {1'b0, divisor});
      rem_sub   = rem_sh[WIDTH-1:0] - divisor;
      rem_next  = take ? rem_sub : rem_sh[WIDTH-1:0];
      quo_next  = {quo[WIDTH-2:0], take};
      div_final = neg ? -quo_next : quo_next;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         neg       <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         rem       <= '0;
         quo       <= '0;
         divisor   <= '0;
         div_zero  <= 1'b0;
         div_ovf   <= 1'b0;
         result    <= '0;
         exception <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start) begin
            cnt      <= '0;
            neg      <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            rem      <= '0;
            quo      <= mag_a;
            divisor  <= mag_b;
            div_zero <= (bus.data_operandB == '0);
            div_ovf  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                        (bus.data_operandB == '1);
         end else if (state == MUL) begin
            cnt    <= cnt + CW'(1);
            acc    <= mul_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last) begin
               result    <= mul_final[WIDTH-1:0];
               exception <= mul_ovf;
            end
         end else if (state == DIV) begin
            cnt <= cnt + CW'(1);
            rem <= rem_next;
            quo <= quo_next;
            if (last) begin
               result    <= div_zero ? '0 : div_final;
               exception <= div_zero | div_ovf;
            end
         end
      end
   end

   assign bus.data_result    = result;
   assign bus.data_exception = exception;
   assign bus.data_resultRDY = (state == DONE);
   assign bus.busy           = (state != IDLE);
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and random checks of multdiv_unit against an arithmetic reference model.
module tb_multdiv_unit;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   multdiv_unit_if #(.WIDTH(32)) bus ();
   multdiv_unit #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint p;
      int     q;
      if (m) begin
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         e = (p != longint'($signed(p[31:0])));
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         q = $signed(a) / $signed(b);
         r = q;
         e = 1'b0;
      end
   endfunction

   // Drives a one-cycle start pulse; returns #1 after the start edge with inputs scrambled.
   task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      @(posedge clock);
      #1;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
   endtask

   task automatic wait_rdy(output int n);
      n = 0;
      while (n < 40) begin
         @(posedge clock);
         #1;
         n++;
         if (bus.data_resultRDY) break;
      end
   endtask

   task automatic run_op(input string tag, input bit m, input bit d,
                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      logic        ee;
      int          n;
      model(m, a, b, er, ee);
      start_op(m, d, a, b);
      check({tag, " busy_start"}, 64'(bus.busy), 64'd1);
      wait_rdy(n);
      check({tag, " latency"}, 64'(n), 64'd32);
      check({tag, " result"}, 64'(bus.data_result), 64'(er));
      check({tag, " exception"}, 64'(bus.data_exception), 64'(ee));
      check({tag, " busy_done"}, 64'(bus.busy), 64'd1);
      @(posedge clock);
      #1;
      check({tag, " rdy_low"}, 64'(bus.data_resultRDY), 64'd0);
      check({tag, " busy_low"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int          n;
      bit          seen;
      bit          m;
      logic [31:0] a, b;

      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;

      repeat (2) @(posedge clock);
      #1;
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset rdy", 64'(bus.data_resultRDY), 64'd0);
      check("reset result", 64'(bus.data_result), 64'd0);
      check("reset exception", 64'(bus.data_exception), 64'd0);
      @(negedge clock);
      reset = 1'b1;

      run_op("mul 7*-3", 1, 0, 32'd7, 32'hFFFF_FFFD);
      check("mul 7*-3 const", 64'(bus.data_result), 64'hFFFF_FFEB);
      repeat (3) @(posedge clock);
      #1;
      check("hold result", 64'(bus.data_result), 64'hFFFF_FFEB);

      run_op("mul ovf 2^16", 1, 0, 32'h0001_0000, 32'h0001_0000);
      run_op("mul ovf max*2", 1, 0, 32'h7FFF_FFFF, 32'd2);
      check("mul max*2 const", 64'(bus.data_result), 64'hFFFF_FFFE);
      run_op("div -17/5", 0, 1, 32'hFFFF_FFEF, 32'd5);
      check("div -17/5 const", 64'(bus.data_result), 64'hFFFF_FFFD);
      run_op("div 17/-5", 0, 1, 32'd17, 32'hFFFF_FFFB);
      run_op("div 4/7", 0, 1, 32'd4, 32'd7);
      run_op("div -4/7", 0, 1, 32'hFFFF_FFFC, 32'd7);
      run_op("div by 0", 0, 1, 32'd123, 32'd0);
      run_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("mul min*min", 1, 0, 32'h8000_0000, 32'h8000_0000);

      // Abort: a DIV issued 10 cycles into a MULT leaves only the DIV's RDY.
      start_op(1, 0, 32'd6, 32'd7);
      seen = 1'b0;
      repeat (9) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY) seen = 1'b1;
      end
      start_op(0, 1, 32'd100, 32'd9);
      check("abort no early rdy", 64'(seen), 64'd0);
      wait_rdy(n);
      check("abort latency", 64'(n), 64'd32);
      check("abort result", 64'(bus.data_result), 64'd11);
      check("abort exception", 64'(bus.data_exception), 64'd0);

      run_op("both ctrl", 1, 1, 32'd3, 32'd4);
      check("both ctrl const", 64'(bus.data_result), 64'd12);

      // Asynchronous reset between edges in the middle of a multiply.
      start_op(1, 0, 32'd5, 32'd5);
      repeat (15) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check("midreset busy", 64'(bus.busy), 64'd0);
      check("midreset rdy", 64'(bus.data_resultRDY), 64'd0);
      check("midreset result", 64'(bus.data_result), 64'd0);
      @(negedge clock);
      bus.ctrl_MULT = 1'b1;
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      reset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY || bus.busy) seen = 1'b1;
      end
      check("no rdy after reset", 64'(seen), 64'd0);
      run_op("mul 2*2", 1, 0, 32'd2, 32'd2);
      check("mul 2*2 const", 64'(bus.data_result), 64'd4);

      for (int i = 0; i < 24; i++) begin
         m = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: begin a = $urandom; b = $urandom; end
            1: begin a = 32'($urandom_range(0, 200)) - 32'd100;
                     b = 32'($urandom_range(0, 200)) - 32'd100; end
            2: begin a = $urandom; b = 32'($urandom_range(0, 40)) - 32'd20; end
            default: begin a = 32'h8000_0000; b = 32'($urandom_range(0, 4)) - 32'd2; end
         endcase
         run_op(m ? "rand mul" : "rand div", m, !m, a, b);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
